// File: rtl/input_port_controller.sv
// Router input port: accepts upstream flits over req/gnt, buffers them in a FIFO,
// XY-routes the head flit and requests the matching output controller.
module input_port_controller #(
    parameter int routerNo   = 24,
    parameter int MESH_COLS  = 5,
    parameter int dataWidth  = 32,
    parameter int DEST_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqUpStr,
    input  logic [dataWidth-1:0] PacketIn,
    output logic                 gntUpStr,
    output logic                 full,
    output logic [4:0]           reqOutCntr,
    input  logic [4:0]           gntOutCntr,
    output logic [dataWidth-1:0] PacketOut
);
    localparam int          PTR_W = $clog2(FIFO_DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam int unsigned COLS  = MESH_COLS;
    localparam int unsigned MY_X  = routerNo % MESH_COLS;
    localparam int unsigned MY_Y  = routerNo / MESH_COLS;

    typedef enum logic       {W_IDLE, W_ACK} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_REL} r_state_t;

    logic [dataWidth-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    w_state_t             r_wstate;
    w_state_t             w_wstate_nxt;
    r_state_t             r_rstate;
    r_state_t             w_rstate_nxt;
    logic                 r_gnt;
    logic [4:0]           r_req;
    logic [dataWidth-1:0] r_pkt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_load;
    logic [dataWidth-1:0] w_head;
    logic [4:0]           w_route;

    // X is resolved before Y; equal coordinates mean the flit leaves on the local port.
    function automatic logic [4:0] xy_route(input logic [DEST_W-1:0] dest);
        int unsigned d;
        int unsigned dx;
        int unsigned dy;
        d  = 32'(dest);
        dx = d % COLS;
        dy = d / COLS;
        if (dx > MY_X)      return 5'b00001;
        else if (dx < MY_X) return 5'b00100;
        else if (dy < MY_Y) return 5'b00010;
        else if (dy > MY_Y) return 5'b01000;
        else                return 5'b10000;
    endfunction

    assign full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_head     = r_mem[r_rd_ptr];
    assign w_route    = xy_route(w_head[dataWidth-1 -: DEST_W]);
    assign gntUpStr   = r_gnt;
    assign reqOutCntr = r_req;
    assign PacketOut  = r_pkt;

    // W_ACK skips a cycle because upstream still holds its request while it sees the grant.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_push       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (reqUpStr && !full) begin
                    w_push       = 1'b1;
                    w_wstate_nxt = W_ACK;
                end
            end
            W_ACK:   w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (r_count != '0) begin
                    w_load       = 1'b1;
                    w_rstate_nxt = R_REQ;
                end
            end
            R_REQ: begin
                if (|(gntOutCntr & r_req)) begin
                    w_pop        = 1'b1;
                    w_rstate_nxt = R_REL;
                end
            end
            R_REL:   w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_gnt    <= 1'b0;
            r_req    <= '0;
            r_pkt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_gnt    <= w_push;
            if (w_load) begin
                r_req <= w_route;
                r_pkt <= w_head;
            end else if (w_pop) begin
                r_req <= '0;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only entries covered by the count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= PacketIn;
    end
endmodule

// File: tb/tb_input_port_controller.sv
// Bench for input_port_controller (router 12 in a 5-column mesh): directed steps plus
// a randomized phase, checked against a queue-based reference of the port behaviour.
module tb_input_port_controller;
    localparam int MX = 12 % 5;
    localparam int MY = 12 / 5;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        reqUpStr   = 1'b0;
    logic [31:0] PacketIn   = '0;
    logic        gntUpStr;
    logic        full;
    logic [4:0]  reqOutCntr;
    logic [4:0]  gntOutCntr = '0;
    logic [31:0] PacketOut;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q[$];

    int          dir_dest [6] = '{14, 10, 2, 22, 12, 23};
    logic [4:0]  dir_exp  [6] = '{5'b00001, 5'b00100, 5'b00010, 5'b01000, 5'b10000, 5'b00001};

    input_port_controller #(
        .routerNo  (12),
        .MESH_COLS (5),
        .dataWidth (32),
        .DEST_W    (5),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reqUpStr  (reqUpStr),
        .PacketIn  (PacketIn),
        .gntUpStr  (gntUpStr),
        .full      (full),
        .reqOutCntr(reqOutCntr),
        .gntOutCntr(gntOutCntr),
        .PacketOut (PacketOut)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] model_route(input logic [31:0] flit);
        int d;
        int dx;
        int dy;
        d  = int'(flit[31:27]);
        dx = d % 5;
        dy = d / 5;
        if (dx > MX)      return 5'b00001;
        else if (dx < MX) return 5'b00100;
        else if (dy < MY) return 5'b00010;
        else if (dy > MY) return 5'b01000;
        else              return 5'b10000;
    endfunction

    function automatic logic [31:0] mk_flit(input logic [4:0] dest);
        logic [31:0] r;
        r = $urandom;
        return {dest, r[26:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] flit);
        bit got;
        got      = 1'b0;
        reqUpStr = 1'b1;
        PacketIn = flit;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (gntUpStr) got = 1'b1;
        end
        reqUpStr = 1'b0;
        check("send_gnt", 32'(got), 32'd1);
        if (got) q.push_back(flit);
        tick();
        check("gnt_one_cycle", 32'(gntUpStr), 32'd0);
    endtask

    task automatic wait_req;
        for (int i = 0; i < 20 && reqOutCntr == 5'b0; i++) tick();
        check("req_seen", 32'(reqOutCntr != 5'b0), 32'd1);
    endtask

    task automatic deliver(input bit wrong_first);
        logic [4:0]  exp;
        logic [31:0] h;
        wait_req();
        if (q.size() == 0) return;
        h   = q[0];
        exp = model_route(h);
        check("route", 32'(reqOutCntr), 32'(exp));
        check("packet", PacketOut, h);
        if (wrong_first) begin
            gntOutCntr = 5'($urandom) & ~exp;
            if (gntOutCntr == 5'b0) gntOutCntr = ~exp;
            tick();
            check("req_hold", 32'(reqOutCntr), 32'(exp));
            check("pkt_hold", PacketOut, h);
        end
        gntOutCntr = exp;
        tick();
        gntOutCntr = '0;
        check("req_drop", 32'(reqOutCntr), 32'd0);
        void'(q.pop_front());
        check("full_after_pop", 32'(full), 32'(q.size() == 4));
    endtask

    initial begin
        logic [31:0] fa;
        logic [31:0] fb;
        int          pulses;
        int          consec;
        bit          prev;
        bit          gseen;

        // Reset state
        tick();
        tick();
        check("rst_gnt", 32'(gntUpStr), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_req", 32'(reqOutCntr), 32'd0);
        check("rst_pkt", PacketOut, 32'd0);
        reset = 1'b1;
        tick();

        // Routing, one flit at a time; request must follow one edge after the push
        for (int i = 0; i < 6; i++) begin
            fa = mk_flit(5'(dir_dest[i]));
            send(fa);
            check("route_latency", 32'(reqOutCntr), 32'(dir_exp[i]));
            deliver(1'b0);
        end

        // Request held across several cycles: one accept every other edge
        fa       = mk_flit(5'($urandom_range(31)));
        reqUpStr = 1'b1;
        PacketIn = fa;
        pulses   = 0;
        consec   = 0;
        prev     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gntUpStr) begin
                pulses++;
                q.push_back(fa);
                if (prev) consec++;
            end
            prev = gntUpStr;
        end
        reqUpStr = 1'b0;
        tick();
        check("hs_pulses", 32'(pulses), 32'd3);
        check("hs_consec", 32'(consec), 32'd0);
        check("hs_full", 32'(full), 32'd0);
        while (q.size() != 0) deliver(1'b0);

        // Fill to capacity, blocked fifth flit, then release by one pop
        for (int i = 0; i < 4; i++) send(mk_flit(5'($urandom_range(31))));
        check("fill_full", 32'(full), 32'd1);
        fb       = mk_flit(5'($urandom_range(31)));
        reqUpStr = 1'b1;
        PacketIn = fb;
        gseen    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (gntUpStr) gseen = 1'b1;
        end
        check("fill_no_gnt", 32'(gseen), 32'd0);
        check("fill_still_full", 32'(full), 32'd1);
        deliver(1'b0);
        tick();
        check("fill_5th_gnt", 32'(gntUpStr), 32'd1);
        q.push_back(fb);
        reqUpStr = 1'b0;
        tick();
        check("fill_full_again", 32'(full), 32'd1);
        while (q.size() != 0) deliver(1'b0);

        // Grant on a non-requested port is ignored
        send(mk_flit(5'd14));
        send(mk_flit(5'($urandom_range(31))));
        wait_req();
        gntOutCntr = 5'b00010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wrong_gnt_req", 32'(reqOutCntr), 32'd1);
            check("wrong_gnt_pkt", PacketOut, q[0]);
        end
        gntOutCntr = '0;
        deliver(1'b0);
        tick();
        check("rel_gap", 32'(reqOutCntr), 32'd0);
        deliver(1'b0);

        // Push and pop on the same edge keep the count and the order
        fa = mk_flit(5'($urandom_range(31)));
        for (int i = 0; i < 3; i++) send(mk_flit(5'($urandom_range(31))));
        wait_req();
        reqUpStr   = 1'b1;
        PacketIn   = fa;
        gntOutCntr = model_route(q[0]);
        tick();
        reqUpStr   = 1'b0;
        gntOutCntr = '0;
        check("simul_gnt", 32'(gntUpStr), 32'd1);
        check("simul_req_drop", 32'(reqOutCntr), 32'd0);
        check("simul_not_full", 32'(full), 32'd0);
        void'(q.pop_front());
        q.push_back(fa);
        tick();
        send(mk_flit(5'($urandom_range(31))));
        check("simul_full", 32'(full), 32'd1);
        while (q.size() != 0) deliver(1'b0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            if (q.size() < 4 && (q.size() == 0 || $urandom_range(1) == 1))
                send(mk_flit(5'($urandom_range(31))));
            else
                deliver(1'($urandom_range(1)));
            check("rand_full", 32'(full), 32'(q.size() == 4));
        end
        while (q.size() != 0) deliver(1'b0);

        // Asynchronous reset while a request is outstanding
        for (int i = 0; i < 3; i++) send(mk_flit(5'($urandom_range(31))));
        wait_req();
        #2;
        reset = 1'b0;
        #1;
        check("arst_gnt", 32'(gntUpStr), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        check("arst_req", 32'(reqOutCntr), 32'd0);
        check("arst_pkt", PacketOut, 32'd0);
        q.delete();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_idle", 32'(reqOutCntr), 32'd0);
        end
        fa = mk_flit(5'($urandom_range(31)));
        send(fa);
        check("post_rst_route", 32'(reqOutCntr), 32'(model_route(fa)));
        deliver(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
